// File: rtl/fetch_decode_unit.sv
// Instruction fetch/decode stage in front of a 256x8 combinational instruction memory.
// Walks the PC, assembles one-byte (ADD/SUB/HLT) and two-byte (LOAD/STORE + address byte)
// instructions, splits them into fields and offers them to execute over valid/ready.
// After HLT is consumed, fetching stops until a redirect or a reset.
module fetch_decode_unit #(
   parameter int unsigned             ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]       RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [3:0]        instr_op,
   output logic [1:0]        instr_rd,
   output logic [1:0]        instr_rs,
   output logic [7:0]        instr_imm,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_illegal,
   output logic              halted,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_IMM = 2'd1,
      ISSUE     = 2'd2,
      HALTED    = 2'd3
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b1001;
   localparam logic [3:0] OP_STORE = 4'b1101;
   localparam logic [3:0] OP_HLT   = 4'b1111;
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   // Opcodes the execute stage understands; anything else is flagged illegal.
   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'b0001, 4'b0010, 4'b1001, 4'b1101, 4'b1111: op_legal = 1'b1;
         default:                                     op_legal = 1'b0;
      endcase
   endfunction

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [3:0]        op_r, op_s;
   logic [1:0]        rd_r, rd_s;
   logic [1:0]        rs_r, rs_s;
   logic [7:0]        imm_r, imm_s;
   logic [ADDR_W-1:0] ipc_r, ipc_s;
   logic              illegal_r, illegal_s;
   logic              valid_r, valid_s;
   logic              halted_r, halted_s;

   // State and instruction/PC registers; everything visible outside is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= FETCH_OP;
         pc_r      <= RESET_PC;
         op_r      <= 4'd0;
         rd_r      <= 2'd0;
         rs_r      <= 2'd0;
         imm_r     <= 8'd0;
         ipc_r     <= {ADDR_W{1'b0}};
         illegal_r <= 1'b0;
         valid_r   <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         op_r      <= op_s;
         rd_r      <= rd_s;
         rs_r      <= rs_s;
         imm_r     <= imm_s;
         ipc_r     <= ipc_s;
         illegal_r <= illegal_s;
         valid_r   <= valid_s;
         halted_r  <= halted_s;
      end
   end

   // Next-state and next-register logic; redirect overrides whatever the FSM decided.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      op_s      = op_r;
      rd_s      = rd_r;
      rs_s      = rs_r;
      imm_s     = imm_r;
      ipc_s     = ipc_r;
      illegal_s = illegal_r;
      valid_s   = valid_r;
      halted_s  = halted_r;

      case (state_r)
         FETCH_OP: begin
            op_s      = imem_data[7:4];
            rd_s      = imem_data[3:2];
            rs_s      = imem_data[1:0];
            ipc_s     = pc_r;
            pc_s      = pc_r + PC_ONE;
            illegal_s = ~op_legal(imem_data[7:4]);
            if ((imem_data[7:4] == OP_LOAD) || (imem_data[7:4] == OP_STORE)) begin
               state_s = FETCH_IMM;
            end else begin
               imm_s   = 8'd0;
               valid_s = 1'b1;
               state_s = ISSUE;
            end
         end
         FETCH_IMM: begin
            imm_s   = imem_data;
            pc_s    = pc_r + PC_ONE;
            valid_s = 1'b1;
            state_s = ISSUE;
         end
         ISSUE: begin
            // Fields and PC hold until execute takes the instruction.
            if (instr_ready) begin
               valid_s = 1'b0;
               if (op_r == OP_HLT) begin
                  halted_s = 1'b1;
                  state_s  = HALTED;
               end else begin
                  state_s  = FETCH_OP;
               end
            end else begin
               state_s = ISSUE;
            end
         end
         HALTED: begin
            valid_s  = 1'b0;
            halted_s = 1'b1;
            state_s  = HALTED;
         end
         default: begin
            valid_s  = 1'b0;
            halted_s = 1'b0;
            state_s  = FETCH_OP;
         end
      endcase

      // A redirect discards any partial instruction and restarts fetch at the new PC.
      if (redirect_valid) begin
         pc_s     = redirect_pc;
         state_s  = FETCH_OP;
         valid_s  = 1'b0;
         halted_s = 1'b0;
      end else begin
         pc_s     = pc_s;
      end
   end

   assign imem_addr     = pc_r;
   assign instr_valid   = valid_r;
   assign instr_op      = op_r;
   assign instr_rd      = rd_r;
   assign instr_rs      = rs_r;
   assign instr_imm     = imm_r;
   assign instr_pc      = ipc_r;
   assign instr_illegal = illegal_r;
   assign halted        = halted_r;

endmodule
